decode_stage: RTL and testbench

- ID stage of the 5-stage pipeline (IF-ID-EX-MEM-WB).
- Takes the fetched instruction from IF and drives the register-file read indices and opcode combinationally.
- Registers the decoded operands into the ID/EX pipeline register.
- Tracks in-flight loads, inserting load-use bubbles and stalling IF; honours EX flush and downstream hold.

---
 rtl/decode_stage.sv | 150 +++++++++++++++
 tb/tb_decode_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: ID stage of the IF-ID-EX-MEM-WB pipeline.
//   Drives register-file read indices/opcode combinationally from the IF
//   instruction, registers the decoded operands into ID/EX, and tracks
//   in-flight loads to insert load-use bubbles and stall IF.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   if_valid/instr/pc  instruction presented by IF
//   flush              EX redirect, kills the instruction in ID
//   hold               EX cannot accept; freezes ID/EX and the load tracker
//   stall_if           IF must hold its instruction this cycle (combinational)
//   fstOpcode, rdIndex1, rdIndex2  register-file read request (combinational)
//   dataOut1, dataOut2 register-file read data (WB write-through included)
//   id_*               ID/EX pipeline register
// Build option:
//   LOAD_MEM_FWD_EN    EX has a MEM->EX load bypass; only the EX-stage load
//                      can cause a hazard, so a load-use costs at most 1 bubble.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  input  logic        hold,
  output logic        stall_if,
  output logic [3:0]  fstOpcode,
  output logic [3:0]  rdIndex1,
  output logic [3:0]  rdIndex2,
  input  logic [31:0] dataOut1,
  input  logic [31:0] dataOut2,
  output logic        id_valid,
  output logic [3:0]  id_op1,
  output logic [3:0]  id_rd,
  output logic        id_wrtEn,
  output logic [31:0] id_src1,
  output logic [31:0] id_src2,
  output logic [31:0] id_imm,
  output logic [31:0] id_pc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;
  localparam int unsigned REGW = 4;
  localparam int unsigned IMMW = 16;

  localparam logic [OPW-1:0] OP1_LW = 4'b1001;
  localparam logic [OPW-1:0] OP1_SW = 4'b0101;
  localparam logic [OPW-1:0] OP1_BR = 4'b0010;

  // Instruction fields
  logic [OPW-1:0]  op1;
  logic [REGW-1:0] rd;
  logic [REGW-1:0] rs1;
  logic [REGW-1:0] rs2;
  logic [IMMW-1:0] imm;

  assign op1 = if_instr[31:28];
  assign rd  = if_instr[27:24];
  assign rs1 = if_instr[23:20];
  assign rs2 = if_instr[19:16];
  assign imm = if_instr[15:0];

  // Register-file read request, straight from IF
  assign fstOpcode = op1;
  assign rdIndex1  = rs1;
  assign rdIndex2  = rs2;

  // Load tracker: loads currently in EX and in MEM
  logic            ldEx_v;
  logic [REGW-1:0] ldEx_rd;
`ifndef LOAD_MEM_FWD_EN
  logic            ldMem_v;
  logic [REGW-1:0] ldMem_rd;
`endif

  logic use1;
  logic use2;
  logic hitEx;
  logic hitMem;
  logic hazard;

  // Load-use hazard detection and IF stall
  always_comb begin
    use1   = if_valid;
    // a load's rs2 field is not read, so it cannot create a dependency
    use2   = if_valid & (op1 != OP1_LW);
    hitEx  = ldEx_v & ((use1 & (rs1 == ldEx_rd)) | (use2 & (rs2 == ldEx_rd)));
`ifdef LOAD_MEM_FWD_EN
    hitMem = 1'b0;
`else
    hitMem = ldMem_v & ((use1 & (rs1 == ldMem_rd)) | (use2 & (rs2 == ldMem_rd)));
`endif
    hazard   = hitEx | hitMem;
    stall_if = ~reset & (hold | (hazard & ~flush));
  end

  // Tracker shifts on every non-hold edge; flush overrides hold
  always_ff @(posedge clk) begin
    if (reset) begin
      ldEx_v   <= 1'b0;
      ldEx_rd  <= '0;
`ifndef LOAD_MEM_FWD_EN
      ldMem_v  <= 1'b0;
      ldMem_rd <= '0;
`endif
    end else if (flush || !hold) begin
`ifndef LOAD_MEM_FWD_EN
      ldMem_v  <= ldEx_v;
      ldMem_rd <= ldEx_rd;
`endif
      if (flush || hazard) begin
        ldEx_v  <= 1'b0;
        ldEx_rd <= '0;
      end else begin
        ldEx_v  <= if_valid & (op1 == OP1_LW);
        ldEx_rd <= rd;
      end
    end
  end

  // ID/EX pipeline register: flush > hold > bubble > capture
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_op1   <= '0;
      id_rd    <= '0;
      id_wrtEn <= 1'b0;
      id_src1  <= '0;
      id_src2  <= '0;
      id_imm   <= '0;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (!hold) begin
      if (hazard) begin
        id_valid <= 1'b0;
      end else begin
        id_valid <= if_valid;
        id_op1   <= op1;
        id_rd    <= rd;
        id_wrtEn <= (op1 != OP1_SW) & (op1 != OP1_BR);
        id_src1  <= dataOut1;
        id_src2  <= dataOut2;
        id_imm   <= XLEN'({{(XLEN-IMMW){imm[IMMW-1]}}, imm});
        id_pc    <= if_pc;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed, table-driven bench for decode_stage.
// Each table row is one clock: inputs applied, stall_if checked before the
// edge, ID/EX outputs checked after it. A hand-written sequence covers a
// multi-cycle hold with an immediate sign-extension on release.
module tb_decode_stage;

  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] LW  = 4'h9;
  localparam logic [3:0] SW  = 4'h5;
  localparam logic [3:0] BR  = 4'h2;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        hold;
  logic        stall_if;
  logic [3:0]  fstOpcode;
  logic [3:0]  rdIndex1;
  logic [3:0]  rdIndex2;
  logic [31:0] dataOut1;
  logic [31:0] dataOut2;
  logic        id_valid;
  logic [3:0]  id_op1;
  logic [3:0]  id_rd;
  logic        id_wrtEn;
  logic [31:0] id_src1;
  logic [31:0] id_src2;
  logic [31:0] id_imm;
  logic [31:0] id_pc;

  decode_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .hold(hold), .stall_if(stall_if),
    .fstOpcode(fstOpcode), .rdIndex1(rdIndex1), .rdIndex2(rdIndex2),
    .dataOut1(dataOut1), .dataOut2(dataOut2), .id_valid(id_valid),
    .id_op1(id_op1), .id_rd(id_rd), .id_wrtEn(id_wrtEn), .id_src1(id_src1),
    .id_src2(id_src2), .id_imm(id_imm), .id_pc(id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fl;
    logic        hd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        eStall;
    logic        eValid;
    logic        chk;
    logic [3:0]  eOp;
    logic [3:0]  eRd;
    logic        eWr;
    logic [31:0] eSrc1;
    logic [31:0] eSrc2;
    logic [31:0] eImm;
    logic [31:0] ePc;
  } vec_t;

  vec_t tbl[$];
  int   total  = 0;
  int   passed = 0;

  function automatic logic [31:0] ins(logic [3:0] op, logic [3:0] rd,
                                      logic [3:0] rs1, logic [3:0] rs2,
                                      logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, exp);
    else
      passed++;
  endtask

  task automatic drive(vec_t r);
    reset    = r.rst;
    if_valid = r.v;
    if_instr = r.instr;
    if_pc    = r.pc;
    flush    = r.fl;
    hold     = r.hd;
    dataOut1 = r.d1;
    dataOut2 = r.d2;
  endtask

  task automatic checkId(int row, logic v, logic [3:0] op, logic [3:0] rd,
                         logic wr, logic [31:0] s1, logic [31:0] s2,
                         logic [31:0] im, logic [31:0] pc);
    chk("id_valid", row, 32'(id_valid), 32'(v));
    chk("id_op1",   row, 32'(id_op1),   32'(op));
    chk("id_rd",    row, 32'(id_rd),    32'(rd));
    chk("id_wrtEn", row, 32'(id_wrtEn), 32'(wr));
    chk("id_src1",  row, id_src1, s1);
    chk("id_src2",  row, id_src2, s2);
    chk("id_imm",   row, id_imm,  im);
    chk("id_pc",    row, id_pc,   pc);
  endtask

  initial begin
    vec_t r;
    // rst v  instr                          pc     fl hd d1         d2         stall valid chk op   rd  wr src1       src2       imm            pc
    tbl.push_back('{1, 0, 32'h0,                          32'h0,   0, 0, 32'h0,     32'h0,     0, 0, 1, 4'h0, 4'h0, 0, 32'h0,     32'h0,     32'h0,         32'h0});
    // ADD r3 <- r1,r2
    tbl.push_back('{0, 1, ins(ADD, 3, 1, 2, 16'h0010),    32'h100, 0, 0, 32'd5,     32'd7,     0, 1, 1, ADD,  4'h3, 1, 32'd5,     32'd7,     32'h10,        32'h100});
    // LW r4 <- [r1+4], then back-to-back consumer ADD r5 <- r4,r1
    tbl.push_back('{0, 1, ins(LW, 4, 1, 0, 16'h0004),     32'h104, 0, 0, 32'h1000,  32'd9,     0, 1, 1, LW,   4'h4, 1, 32'h1000,  32'd9,     32'h4,         32'h104});
    tbl.push_back('{0, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h108, 0, 0, 32'd11,    32'd22,    1, 0, 0, 0,    0,    0, 0,         0,         0,             0});
`ifdef LOAD_MEM_FWD_EN
    tbl.push_back('{0, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h108, 0, 0, 32'd11,    32'd22,    0, 1, 1, ADD,  4'h5, 1, 32'd11,    32'd22,    32'h0,         32'h108});
`else
    tbl.push_back('{0, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h108, 0, 0, 32'd11,    32'd22,    1, 0, 0, 0,    0,    0, 0,         0,         0,             0});
    tbl.push_back('{0, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h108, 0, 0, 32'd11,    32'd22,    0, 1, 1, ADD,  4'h5, 1, 32'd11,    32'd22,    32'h0,         32'h108});
`endif
    // LW r4, SW (independent), consumer ADD r6 <- r4,r4
    tbl.push_back('{0, 1, ins(LW, 4, 2, 0, 16'h0000),     32'h10C, 0, 0, 32'h2000,  32'h0,     0, 1, 1, LW,   4'h4, 1, 32'h2000,  32'h0,     32'h0,         32'h10C});
    tbl.push_back('{0, 1, ins(SW, 0, 2, 3, 16'h0008),     32'h110, 0, 0, 32'd1,     32'd2,     0, 1, 1, SW,   4'h0, 0, 32'd1,     32'd2,     32'h8,         32'h110});
`ifdef LOAD_MEM_FWD_EN
    tbl.push_back('{0, 1, ins(ADD, 6, 4, 4, 16'h0000),    32'h114, 0, 0, 32'd3,     32'd4,     0, 1, 1, ADD,  4'h6, 1, 32'd3,     32'd4,     32'h0,         32'h114});
`else
    tbl.push_back('{0, 1, ins(ADD, 6, 4, 4, 16'h0000),    32'h114, 0, 0, 32'd3,     32'd4,     1, 0, 0, 0,    0,    0, 0,         0,         0,             0});
    tbl.push_back('{0, 1, ins(ADD, 6, 4, 4, 16'h0000),    32'h114, 0, 0, 32'd3,     32'd4,     0, 1, 1, ADD,  4'h6, 1, 32'd3,     32'd4,     32'h0,         32'h114});
`endif
    // LW r4, then LW r6 whose unused rs2 field is r4: no bubble; then BR
    tbl.push_back('{0, 1, ins(LW, 4, 1, 0, 16'h0000),     32'h118, 0, 0, 32'h0,     32'h0,     0, 1, 0, 0,    0,    0, 0,         0,         0,             0});
    tbl.push_back('{0, 1, ins(LW, 6, 1, 4, 16'h0000),     32'h11C, 0, 0, 32'h40,    32'h50,    0, 1, 1, LW,   4'h6, 1, 32'h40,    32'h50,    32'h0,         32'h11C});
    tbl.push_back('{0, 1, ins(BR, 0, 1, 2, 16'hFFFE),     32'h120, 0, 0, 32'd1,     32'd1,     0, 1, 1, BR,   4'h0, 0, 32'd1,     32'd1,     32'hFFFFFFFE,  32'h120});
    // LW r4, consumer flushed in its first stall cycle, unrelated ADD next
    tbl.push_back('{0, 1, ins(LW, 4, 1, 0, 16'h0000),     32'h124, 0, 0, 32'h0,     32'h0,     0, 1, 0, 0,    0,    0, 0,         0,         0,             0});
    tbl.push_back('{0, 1, ins(ADD, 7, 4, 2, 16'h0000),    32'h128, 1, 0, 32'h0,     32'h0,     0, 0, 0, 0,    0,    0, 0,         0,         0,             0});
    tbl.push_back('{0, 1, ins(ADD, 8, 1, 2, 16'h0000),    32'h12C, 0, 0, 32'd5,     32'd6,     0, 1, 1, ADD,  4'h8, 1, 32'd5,     32'd6,     32'h0,         32'h12C});
    // Reset mid-run with a load in EX; dependent ADD issues right after
    tbl.push_back('{0, 1, ins(LW, 4, 1, 0, 16'h0000),     32'h130, 0, 0, 32'h0,     32'h0,     0, 1, 0, 0,    0,    0, 0,         0,         0,             0});
    tbl.push_back('{1, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h134, 0, 0, 32'd7,     32'd8,     0, 0, 1, 4'h0, 4'h0, 0, 32'h0,     32'h0,     32'h0,         32'h0});
    tbl.push_back('{0, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h134, 0, 0, 32'd7,     32'd8,     0, 1, 1, ADD,  4'h5, 1, 32'd7,     32'd8,     32'h0,         32'h134});
    // Invalid IF slot never creates a hazard
    tbl.push_back('{0, 1, ins(LW, 9, 1, 0, 16'h0000),     32'h138, 0, 0, 32'h0,     32'h0,     0, 1, 0, 0,    0,    0, 0,         0,         0,             0});
    tbl.push_back('{0, 0, ins(ADD, 1, 9, 9, 16'h0000),    32'h13C, 0, 0, 32'h0,     32'h0,     0, 0, 0, 0,    0,    0, 0,         0,         0,             0});
    // Hold during a load-use: tracker frozen, so the full bubble count follows
    tbl.push_back('{0, 1, ins(LW, 4, 1, 0, 16'h0004),     32'h140, 0, 0, 32'h3000,  32'h0,     0, 1, 1, LW,   4'h4, 1, 32'h3000,  32'h0,     32'h4,         32'h140});
    tbl.push_back('{0, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h144, 0, 1, 32'd1,     32'd2,     1, 1, 1, LW,   4'h4, 1, 32'h3000,  32'h0,     32'h4,         32'h140});
    tbl.push_back('{0, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h144, 0, 0, 32'd1,     32'd2,     1, 0, 0, 0,    0,    0, 0,         0,         0,             0});
`ifdef LOAD_MEM_FWD_EN
    tbl.push_back('{0, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h144, 0, 0, 32'd1,     32'd2,     0, 1, 1, ADD,  4'h5, 1, 32'd1,     32'd2,     32'h0,         32'h144});
`else
    tbl.push_back('{0, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h144, 0, 0, 32'd1,     32'd2,     1, 0, 0, 0,    0,    0, 0,         0,         0,             0});
    tbl.push_back('{0, 1, ins(ADD, 5, 4, 1, 16'h0000),    32'h144, 0, 0, 32'd1,     32'd2,     0, 1, 1, ADD,  4'h5, 1, 32'd1,     32'd2,     32'h0,         32'h144});
`endif

    drive(tbl[0]);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      drive(r);
      #1;
      chk("stall_if",  i, 32'(stall_if),  32'(r.eStall));
      chk("fstOpcode", i, 32'(fstOpcode), 32'(r.instr[31:28]));
      chk("rdIndex1",  i, 32'(rdIndex1),  32'(r.instr[23:20]));
      chk("rdIndex2",  i, 32'(rdIndex2),  32'(r.instr[19:16]));
      @(posedge clk);
      #1;
      if (r.chk)
        checkId(i, r.eValid, r.eOp, r.eRd, r.eWr, r.eSrc1, r.eSrc2, r.eImm, r.ePc);
      else
        chk("id_valid", i, 32'(id_valid), 32'(r.eValid));
    end

    // Hand sequence: issue ADD r10, hold 3 cycles while IF changes, release
    reset = 0; flush = 0; hold = 0; if_valid = 1;
    if_instr = ins(ADD, 10, 1, 2, 16'h1234); if_pc = 32'h200;
    dataOut1 = 32'hAA; dataOut2 = 32'hBB;
    #1;
    chk("hs_stall_pre", 100, 32'(stall_if), 32'h0);
    @(posedge clk); #1;
    checkId(100, 1, ADD, 4'hA, 1, 32'hAA, 32'hBB, 32'h1234, 32'h200);
    for (int c = 0; c < 3; c++) begin
      hold = 1;
      if_instr = ins(ADD, 11, 3, 4, 16'h8001); if_pc = 32'h204;
      dataOut1 = 32'hCC + 32'(c); dataOut2 = 32'hDD;
      #1;
      chk("hs_stall_hold", 101 + c, 32'(stall_if), 32'h1);
      @(posedge clk); #1;
      checkId(101 + c, 1, ADD, 4'hA, 1, 32'hAA, 32'hBB, 32'h1234, 32'h200);
    end
    hold = 0;
    dataOut1 = 32'hCC; dataOut2 = 32'hDD;
    #1;
    chk("hs_stall_rel", 104, 32'(stall_if), 32'h0);
    @(posedge clk); #1;
    checkId(104, 1, ADD, 4'hB, 1, 32'hCC, 32'hDD, 32'hFFFF8001, 32'h204);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
